// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM encoding,
// address-map geometry and timeout counter width.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int          APB_PAGE_BITS = 12;
    localparam int          PAGE_W        = 32 - APB_PAGE_BITS;
    localparam logic [19:0] APB_BASE_PAGE = 20'h10000;
    localparam int          TIMEOUT_W     = 8;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: slave i owns the 4 KiB page BASE_PAGE + i.
// hit is low for any address outside the NSLV-page window.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NSLV      = 4,
    parameter logic [PAGE_W-1:0] BASE_PAGE = APB_BASE_PAGE
) (
    input  logic [31:0]     addr,
    output logic [NSLV-1:0] sel,
    output logic            hit
);

    logic [PAGE_W-1:0] page;

    assign page = addr[31:APB_PAGE_BITS];

    always_comb begin
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel[i] = (page == BASE_PAGE + PAGE_W'(i));
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-cycle core requests into SETUP/ACCESS transfers,
// muxes the selected slave's response back, and errors out unmapped or stalled accesses.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int                NSLV        = 4,
    parameter logic [PAGE_W-1:0] BASE_PAGE   = APB_BASE_PAGE,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 transfer,
    input  logic                 write,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 err,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [NSLV-1:0]      PSEL,
    input  logic [NSLV*32-1:0]   PRDATA_s,
    input  logic [NSLV-1:0]      PREADY_s
);

    apb_state_t            state, next_state;
    logic [NSLV-1:0]       dec_sel, sel_q;
    logic                  dec_hit, hit_q;
    logic [TIMEOUT_W-1:0]  wait_cnt;
    logic                  pready_sel;
    logic [31:0]           prdata_sel;
    logic                  timeout_hit;

    apb_addr_decoder #(
        .NSLV      (NSLV),
        .BASE_PAGE (BASE_PAGE)
    ) u_decoder (
        .addr (addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Only the latched slave's response is consulted; everyone else is masked off.
    assign pready_sel  = |(PREADY_s & sel_q);
    assign timeout_hit = (wait_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1)) && !pready_sel;

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                prdata_sel = prdata_sel | PRDATA_s[32*i +: 32];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments for all clocked state avoid simulation races.
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (transfer) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (!hit_q || pready_sel || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        PSEL    = '0;
        PENABLE = 1'b0;
        case (state)
            SETUP:   PSEL = sel_q;
            ACCESS: begin
                PSEL    = sel_q;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR    <= '0;
            PWDATA   <= '0;
            PWRITE   <= 1'b0;
            sel_q    <= '0;
            hit_q    <= 1'b0;
            wait_cnt <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;

            if (state == IDLE && transfer) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
                sel_q  <= dec_sel;
                hit_q  <= dec_hit;
            end

            if (state == ACCESS) begin
                // A slave answering on the last allowed cycle beats the timeout.
                if (hit_q && pready_sel) begin
                    ready    <= 1'b1;
                    rdata    <= PWRITE ? 32'd0 : prdata_sel;
                    wait_cnt <= '0;
                end else if (!hit_q || timeout_hit) begin
                    ready    <= 1'b1;
                    err      <= 1'b1;
                    rdata    <= '0;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized
// transfers checked cycle-by-cycle against an address-map / latency reference model.
module tb_apb_master_bridge;

    localparam int NSLV        = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int NEVER       = 1000;

    logic                 PCLK;
    logic                 PRESET;
    logic                 transfer;
    logic                 write;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 ready;
    logic                 err;
    logic [31:0]          PADDR;
    logic [31:0]          PWDATA;
    logic                 PWRITE;
    logic                 PENABLE;
    logic [NSLV-1:0]      PSEL;
    logic [NSLV*32-1:0]   PRDATA_s;
    logic [NSLV-1:0]      PREADY_s;

    int                   checks = 0;
    int                   errors = 0;

    // Bench-side slave: the selected slave raises PREADY after slv_wait ACCESS cycles;
    // unselected slaves drive random noise that the bridge must ignore.
    int                   slv_wait = 0;
    int                   acc_n    = 0;
    logic [NSLV-1:0]      noise    = '0;
    logic [31:0]          last_rdata = '0;

    apb_master_bridge #(
        .NSLV        (NSLV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA_s (PRDATA_s),
        .PREADY_s (PREADY_s)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) acc_n <= PENABLE ? acc_n + 1 : 0;

    always_comb begin
        PREADY_s = '0;
        for (int i = 0; i < NSLV; i++) begin
            PREADY_s[i] = PSEL[i] ? (acc_n >= slv_wait) : noise[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference address map: which slave owns an address, or -1 if unmapped.
    function automatic int slave_of(input logic [31:0] a);
        int unsigned page;
        page = a >> 12;
        if (page >= 32'h10000 && page < 32'h10000 + NSLV) return int'(page - 32'h10000);
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".ready"}, ready, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".rdata"}, rdata, last_rdata);
        check({tag, ".psel"}, PSEL, 0);
        check({tag, ".penable"}, PENABLE, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLK);
            transfer = 1'b0;
            noise    = NSLV'($urandom);
            check_quiet("idle");
        end
    endtask

    // Present one transfer at the current negedge (DUT must be IDLE) and follow it
    // to its ready cycle; returns at the negedge of the ready cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int wt, input logic [31:0] sel_val, input bit ones, input bit spur);
        int              idx;
        int              rdy_cyc;
        logic            exp_err;
        logic [31:0]     exp_rdata;
        logic [NSLV-1:0] exp_sel;
        logic [NSLV-1:0] one;

        idx = slave_of(a);
        one = 1;
        exp_sel = (idx < 0) ? '0 : (one << idx);
        if (idx < 0) begin
            rdy_cyc = 3;  exp_err = 1'b1;
        end else if (wt < TIMEOUT_CYC) begin
            rdy_cyc = 3 + wt;  exp_err = 1'b0;
        end else begin
            rdy_cyc = 2 + TIMEOUT_CYC;  exp_err = 1'b1;
        end
        exp_rdata = (idx >= 0 && !w && !exp_err) ? sel_val : 32'd0;

        slv_wait = wt;
        for (int i = 0; i < NSLV; i++) begin
            PRDATA_s[32*i +: 32] = (i == idx) ? sel_val : (ones ? 32'hFFFF_FFFF : $urandom);
        end

        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
        for (int c = 1; c <= rdy_cyc; c++) begin
            @(negedge PCLK);
            noise = NSLV'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            write = ~w;
            transfer = (spur && c <= 2);
            if (c < rdy_cyc) begin
                check("busy.psel", PSEL, exp_sel);
                check("busy.penable", PENABLE, (c >= 2));
                check("busy.ready", ready, 0);
                check("busy.paddr", PADDR, a);
                check("busy.pwdata", PWDATA, d);
                check("busy.pwrite", PWRITE, w);
            end else begin
                check("done.ready", ready, 1);
                check("done.err", err, exp_err);
                check("done.rdata", rdata, exp_rdata);
                check("done.psel", PSEL, 0);
                check("done.penable", PENABLE, 0);
            end
        end
        last_rdata = exp_rdata;
    endtask

    initial begin
        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        PRDATA_s = '0;

        // Reset state
        #2 PRESET = 1'b1;
        #1;
        check("rst.psel", PSEL, 0);
        check("rst.penable", PENABLE, 0);
        check("rst.ready", ready, 0);
        check("rst.err", err, 0);
        check("rst.rdata", rdata, 0);
        check("rst.paddr", PADDR, 0);
        check("rst.pwdata", PWDATA, 0);
        check("rst.pwrite", PWRITE, 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        idle(2);

        // Write to slave 3 with one wait state: ready in cycle 4
        xfer(1'b1, 32'h1000_3000, 32'h0000_0003, 1, $urandom, 1'b0, 1'b0);
        idle(1);
        // Zero-wait read from slave 1, other slaves drive all-ones
        xfer(1'b0, 32'h1000_1004, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 1'b0);
        idle(2);
        // Unmapped read
        xfer(1'b0, 32'h2000_0000, 32'h0, 0, $urandom, 1'b0, 1'b0);
        idle(1);
        // Slave 0 never answers: timeout, then slave 2 completes normally
        xfer(1'b0, 32'h1000_0010, 32'h0, NEVER, $urandom, 1'b0, 1'b0);
        idle(1);
        xfer(1'b0, 32'h1000_2008, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
        idle(1);
        // Timeout boundary: answering on the 16th ACCESS cycle wins, one later loses
        xfer(1'b0, 32'h1000_1000, 32'h0, TIMEOUT_CYC - 1, 32'hA5A5_0001, 1'b0, 1'b0);
        xfer(1'b0, 32'h1000_1000, 32'h0, TIMEOUT_CYC, 32'hA5A5_0002, 1'b0, 1'b0);
        // Back-to-back with transfer pulses during SETUP/ACCESS that must be ignored
        xfer(1'b1, 32'h1000_2FFC, 32'hDEAD_BEEF, 0, $urandom, 1'b0, 1'b1);
        xfer(1'b0, 32'h1000_0000, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, 1'b1);
        idle(3);

        // Reset during ACCESS of a read: outputs clear at once, no ready pulse
        slv_wait = NEVER;
        transfer = 1'b1;  write = 1'b0;  addr = 32'h1000_1000;  wdata = '0;
        @(negedge PCLK);
        transfer = 1'b0;
        repeat (2) @(negedge PCLK);
        check("pre_rst.penable", PENABLE, 1);
        PRESET = 1'b1;
        #1;
        check("mid_rst.psel", PSEL, 0);
        check("mid_rst.penable", PENABLE, 0);
        check("mid_rst.paddr", PADDR, 0);
        check("mid_rst.pwrite", PWRITE, 0);
        check("mid_rst.ready", ready, 0);
        check("mid_rst.rdata", rdata, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        last_rdata = '0;
        idle(3);
        xfer(1'b0, 32'h1000_3020, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
        idle(1);

        // Randomized transfers against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          wt;
            int          kind;
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = {20'h10000 + 20'($urandom_range(0, NSLV - 1)), 12'($urandom)};
            else if (kind == 7) a = {20'h10000 + 20'(NSLV), 12'($urandom)};
            else if (kind == 8) a = {20'h0FFFF, 12'($urandom)};
            else                a = $urandom;
            wt = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            xfer(1'($urandom), a, $urandom, wt, $urandom, 1'b0, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
